// File: rtl/stream_mux_n.sv
// stream_mux_n: N-way packet-locked valid/ready stream mux with a registered output stage.
// Define RR_ARB_EN for round-robin grant in IDLE; otherwise the sel port chooses the channel.
module stream_mux_n #(
  parameter int N = 4,
  parameter int WIDTH = 8,
  localparam int SEL_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy,
  output logic [SEL_W-1:0]   cur_sel
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state, state_nx;
  logic found, load, beat, ch_last;
  logic [SEL_W-1:0] pick;
  logic [WIDTH-1:0] ch_data;
  assign busy = state == LOCKED;
  assign load = ~out_valid | out_ready;
  assign ch_data = in_data[int'(cur_sel)*WIDTH +: WIDTH];
  assign ch_last = in_last[cur_sel];
  assign beat = busy & load & in_valid[cur_sel];
`ifdef RR_ARB_EN
  logic unused_sel;
  assign unused_sel = ^sel;
  // Descending scan so the nearest channel after cur_sel wins; cur_sel itself is checked last.
  always_comb begin
    found = 1'b0;
    pick = cur_sel;
    for (int i = N; i >= 1; i--)
      if (in_valid[(int'(cur_sel) + i) % N]) begin
        found = 1'b1;
        pick = SEL_W'((int'(cur_sel) + i) % N);
      end
  end
`else
  always_comb begin
    found = 1'b0;
    pick = sel;
    for (int i = 0; i < N; i++)
      if (int'(sel) == i && in_valid[i]) found = 1'b1;
  end
`endif
  always_comb begin
    in_ready = '0;
    if (busy) in_ready[cur_sel] = load;
  end
  always_comb state_nx = busy ? ((beat && ch_last) ? IDLE : LOCKED) : (found ? LOCKED : IDLE);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur_sel <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
    end else begin
      state <= state_nx;
      if (!busy && found) cur_sel <= pick;
      if (beat) begin
        out_data <= ch_data;
        out_last <= ch_last;
        out_valid <= 1'b1;
      end else if (load) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n: randomized and directed checks of stream_mux_n against a packet-level scoreboard.
module tb_stream_mux_n;
  localparam int N = 4;
  localparam int W = 8;
  typedef struct {logic [W-1:0] d; logic l;} beat_t;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid, in_last, in_ready;
  logic [W-1:0] out_data;
  logic out_valid, out_last, out_ready, busy;
  logic [1:0] cur_sel;
  logic [2:0] sel5, cur_sel5;
  logic [5*W-1:0] in_data5;
  logic [4:0] in_valid5, in_last5, in_ready5;
  logic [W-1:0] out_data5;
  logic out_valid5, out_last5, busy5;
  logic drv_rst, drv_ready;
  logic [1:0] drv_sel;
  logic [N*W-1:0] drv_data;
  logic [N-1:0] drv_valid, drv_last;
  int n_checks = 0;
  int n_errors = 0;
  bit m_locked;
  int m_ch;
  int acc_ch;
  beat_t exp_q[$];
  logic [W-1:0] fired[$];
  int grants[$];
  logic [7:0] b;
  int plen[N], pidx[N];
  logic [W-1:0] pbase[N];

  stream_mux_n #(.N(N), .WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .sel(sel), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .cur_sel(cur_sel));

  stream_mux_n #(.N(5), .WIDTH(W)) u_dut5 (
    .clk(clk), .rst(rst), .sel(sel5), .in_data(in_data5), .in_valid(in_valid5),
    .in_last(in_last5), .in_ready(in_ready5), .out_data(out_data5), .out_valid(out_valid5),
    .out_last(out_last5), .out_ready(1'b1), .busy(busy5), .cur_sel(cur_sel5));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: apply drv_* after the falling edge, compare against the scoreboard,
  // then advance the packet-level model to what the next rising edge should produce.
  task automatic step();
    bit ov;
    logic [N-1:0] exp_rdy;
    int c;
    @(negedge clk);
    rst = drv_rst; sel = drv_sel; in_valid = drv_valid; in_last = drv_last;
    in_data = drv_data; out_ready = drv_ready;
    #1;
    ov = exp_q.size() != 0;
    check("busy", busy, m_locked);
    check("cur_sel", cur_sel, m_ch);
    check("out_valid", out_valid, ov);
    if (ov) begin
      check("out_data", out_data, exp_q[0].d);
      check("out_last", out_last, exp_q[0].l);
    end
    exp_rdy = '0;
    if (m_locked && (!ov || out_ready)) exp_rdy[m_ch] = 1'b1;
    check("in_ready", in_ready, exp_rdy);
    acc_ch = -1;
    if (out_valid && out_ready) fired.push_back(out_data);
    if (rst) begin
      m_locked = 0; m_ch = 0; exp_q.delete();
    end else begin
      if (ov && out_ready) void'(exp_q.pop_front());
      if (m_locked) begin
        if (in_valid[m_ch] && (!ov || out_ready)) begin
          acc_ch = m_ch;
          exp_q.push_back('{in_data[m_ch*W +: W], in_last[m_ch]});
          if (in_last[m_ch]) m_locked = 0;
        end
      end else begin
`ifdef RR_ARB_EN
        for (int i = 1; i <= N; i++) begin
          c = (m_ch + i) % N;
          if (!m_locked && in_valid[c]) begin
            m_locked = 1; m_ch = c; grants.push_back(c);
          end
        end
`else
        if (in_valid[sel]) begin
          m_locked = 1; m_ch = int'(sel); grants.push_back(m_ch);
        end
`endif
      end
    end
  endtask

  task automatic new_pkt(input int k);
    plen[k] = 1 + $urandom % 4;
    pidx[k] = 0;
    pbase[k] = W'($urandom);
  endtask

  initial begin
    drv_rst = 1; drv_sel = 0; drv_data = '0; drv_valid = '0; drv_last = '0; drv_ready = 1;
    sel5 = 3'd5; in_valid5 = '1; in_last5 = '1; in_data5 = '0;
    m_locked = 0; m_ch = 0;
    step(); step();
    drv_rst = 0;
    step();
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_cur_sel", cur_sel, 0);
    check("rst_in_ready", in_ready, 0);
    // Three-beat packet on channel 2 with an always-ready sink.
    drv_sel = 2; drv_valid = 4'b0100;
    drv_data[16 +: 8] = 8'h11; step(); step();
    drv_data[16 +: 8] = 8'h22; step();
    check("t1_beat0", out_data, 8'h11);
    drv_data[16 +: 8] = 8'h33; drv_last = 4'b0100; step();
    check("t1_beat1", out_data, 8'h22);
    drv_valid = '0; drv_last = '0; step();
    check("t1_beat2", out_data, 8'h33);
    check("t1_last", out_last, 1);
    check("t1_busy", busy, 0);
    step();
    // Sink stalls five cycles mid-packet.
    b = 0; fired.delete();
    for (int c = 0; c < 20; c++) begin
      drv_sel = 2; drv_valid = (b < 4) ? 4'b0100 : 4'b0000;
      drv_data[16 +: 8] = 8'hA0 + b; drv_last = (b == 3) ? 4'b0100 : 4'b0000;
      drv_ready = !(c >= 3 && c < 8);
      step();
      if (c >= 3 && c < 8) begin
        check("t3_hold", out_data, 8'hA1);
        check("t3_rdy", in_ready[2], 0);
      end
      if (acc_ch == 2) b++;
    end
    check("t3_count", fired.size(), 4);
    for (int i = 0; i < 4 && i < fired.size(); i++) check("t3_seq", fired[i], 8'hA0 + i);
    // Reset while the third beat of a four-beat packet is presented.
    b = 0; drv_ready = 1;
    for (int c = 0; c < 8; c++) begin
      drv_sel = 1; drv_valid = 4'b0010; drv_data[8 +: 8] = 8'hB0 + b;
      drv_last = (b == 3) ? 4'b0010 : 4'b0000; drv_rst = (b == 2);
      step();
      if (drv_rst) break;
      if (acc_ch == 1) b++;
    end
    drv_rst = 0; drv_valid = '0; drv_last = '0;
    step();
    check("t4_out_valid", out_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_cur_sel", cur_sel, 0);
    b = 0; fired.delete();
    for (int c = 0; c < 8; c++) begin
      drv_sel = 3; drv_valid = (b < 2) ? 4'b1000 : 4'b0000;
      drv_data[24 +: 8] = 8'hC0 + b; drv_last = (b == 1) ? 4'b1000 : 4'b0000;
      step();
      if (acc_ch == 3) b++;
    end
    check("t4_count", fired.size(), 2);
    for (int i = 0; i < 2 && i < fired.size(); i++) check("t4_seq", fired[i], 8'hC0 + i);
`ifndef RR_ARB_EN
    // Out-of-range select on a five-channel instance never grants.
    for (int v = 5; v < 8; v++) begin
      sel5 = 3'(v);
      step();
      check("sel_oor_busy", busy5, 0);
      check("sel_oor_rdy", in_ready5, 0);
    end
`endif
    for (int k = 0; k < N; k++) new_pkt(k);
    for (int c = 0; c < 3000; c++) begin
      drv_rst = ($urandom % 300) == 0;
      drv_sel = 2'($urandom);
      drv_ready = ($urandom % 4) != 0;
      for (int k = 0; k < N; k++) begin
        drv_data[k*W +: W] = W'(pbase[k] + W'(pidx[k]));
        drv_last[k] = pidx[k] == plen[k] - 1;
        drv_valid[k] = ($urandom % 4) != 0;
      end
      step();
      if (acc_ch >= 0) begin
        pidx[acc_ch]++;
        if (pidx[acc_ch] == plen[acc_ch]) new_pkt(acc_ch);
      end
    end
`ifdef RR_ARB_EN
    // Every channel offers single-beat packets; grants must rotate starting after channel 0.
    drv_rst = 1; drv_valid = '0; drv_ready = 1; step();
    drv_rst = 0; grants.delete();
    drv_valid = '1; drv_last = '1;
    for (int k = 0; k < N; k++) drv_data[k*W +: W] = 8'h40 + W'(k);
    for (int c = 0; c < 20 && grants.size() < 8; c++) step();
    check("rr_count", grants.size(), 8);
    for (int i = 0; i < 8 && i < grants.size(); i++) check("rr_order", grants[i], (i + 1) % N);
`endif
    drv_valid = '0; drv_last = '0; drv_ready = 1;
    step(); step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
